// File: rtl/p2s_pkg.sv
// p2s_pkg: shared constants, FSM states and bit-reversal helper for p_to_s.
package p2s_pkg;
  localparam int WIDTH_DEF = 10;
  localparam int N_DEF = 64;
  typedef enum logic {IDLE, SHIFT} state_t;
  function automatic logic [31:0] bit_reverse(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r[i] = v[w-1-i];
    return r;
  endfunction
endpackage

// File: rtl/p2s_index_gen.sv
// p2s_index_gen: frame word counter with wrap flag; bit-reversed index when P2S_BIT_REVERSE_EN.
module p2s_index_gen
  import p2s_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 en,
  output logic [$clog2(N)-1:0] cnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 wrap
);
  localparam int CNT_W = $clog2(N);
  always_ff @(posedge clk) cnt <= clr ? '0 : en ? cnt + CNT_W'(1) : cnt;
`ifdef P2S_BIT_REVERSE_EN
  assign idx = CNT_W'(bit_reverse(32'(cnt), CNT_W));
`else
  assign idx = cnt;
`endif
  assign wrap = cnt == CNT_W'(N - 1);
endmodule

// File: rtl/p_to_s.sv
// p_to_s: double-buffered parallel-to-serial frame converter with sof/eof framing.
// P2S_BIT_REVERSE_EN selects bit-reversed word order within each frame.
module p_to_s
  import p2s_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int N = N_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] i_data,
  input  logic               i_load,
  output logic               o_ready,
  output logic [WIDTH-1:0]   Y,
  output logic               o_valid,
  output logic               o_sof,
  output logic               o_eof,
  output logic               o_overflow
);
  localparam int CNT_W = $clog2(N);
  state_t state, state_nxt;
  logic [N*WIDTH-1:0] active, pending;
  logic pending_full, load_ok, shift, wrap, sof_nxt, eof_nxt;
  logic [CNT_W-1:0] cnt, idx;
  logic [WIDTH-1:0] y_nxt;
  assign o_ready = !pending_full;
  assign load_ok = i_load && o_ready;
  assign shift = state == SHIFT;
  p2s_index_gen #(.N(N)) u_idx (
    .clk (clk),
    .clr (!reset || !shift),
    .en  (shift),
    .cnt (cnt),
    .idx (idx),
    .wrap(wrap)
  );
  always_ff @(posedge clk) state <= !reset ? IDLE : state_nxt;
  always_comb state_nxt = shift ? ((wrap && !pending_full && !load_ok) ? IDLE : SHIFT)
                                : (load_ok ? SHIFT : IDLE);
  always_comb begin
    y_nxt = shift ? active[idx*WIDTH +: WIDTH] : '0;
    sof_nxt = shift && cnt == '0;
    eof_nxt = shift && wrap;
  end
  // A load landing on the last word (or in IDLE) bypasses pending straight into active.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pending_full <= 1'b0;
      o_overflow <= 1'b0;
      Y <= '0;
      o_valid <= 1'b0;
      o_sof <= 1'b0;
      o_eof <= 1'b0;
    end else begin
      Y <= y_nxt;
      o_valid <= shift;
      o_sof <= sof_nxt;
      o_eof <= eof_nxt;
      if (i_load && pending_full) o_overflow <= 1'b1;
      if (load_ok && (!shift || wrap)) active <= i_data;
      else if (shift && wrap && pending_full) begin
        active <= pending;
        pending_full <= 1'b0;
      end
      if (load_ok && shift && !wrap) begin
        pending <= i_data;
        pending_full <= 1'b1;
      end
    end
  end
endmodule
